prog_run_ctrl: RTL and testbench
================================

Name: prog_run_ctrl

Overview:
Sequencing controller for the single-cycle MIPS datapath. It streams a program into instruction memory over a valid/ready handshake, holding the CPU in reset while it loads. It then clears the register file, releases the PC and runs until a halt word, a cycle limit or an abort. While the CPU is not running it drives a write-inhibit that top level ANDs into RegWr and MemWr.

Parameters:
ADDR_W, 5, instruction-memory word-address width; depth = 2**ADDR_W
DATA_W, 32, instruction word width
HALT_WORD, 32'h0000000C, instruction encoding (syscall) that terminates a run
CNT_W, 16, cycle-counter width; the run limit is 2**CNT_W-1 cycles

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous active-high reset
load_start  in  1  one-cycle request to begin loading
load_len  in  ADDR_W+1  number of words to load; legal range 1..2**ADDR_W
in_valid  in  1  load data valid
in_data  in  DATA_W  load data word
in_ready  out  1  controller accepts in_data
run_start  in  1  one-cycle request to run the loaded program
abort  in  1  terminate the current run
instr  in  DATA_W  current Instruction fetched by the datapath
ins_wr_en  out  1  to datapath InsWrEN
ins_wr_addr  out  ADDR_W  to datapath InsWrAddr
ins_data  out  DATA_W  to datapath InsDataIn
cpu_nrst  out  1  to datapath nRST; low holds PC at 0
cpu_nclear  out  1  to datapath nclear; low clears the register file
wr_inhibit  out  1  high blocks RegWr/MemWr
busy  out  1  high in LOAD, CLR and RUN
done  out  1  level; high in DONE
halt_reason  out  2  00 none, 01 halt word, 10 timeout, 11 abort
cycle_count  out  CNT_W  RUN cycles of the last or current run
load_err  out  1  one-cycle pulse on an illegal load_len

Behaviour:
- States: IDLE, LOAD, ARMED, CLR, RUN, DONE. All outputs except in_ready, ins_wr_en, ins_wr_addr and ins_data are registered or decoded from state.
- Reset (clr=1, async): state IDLE; cpu_nrst=0, cpu_nclear=0, wr_inhibit=1, in_ready=0, ins_wr_en=0, busy=0, done=0, halt_reason=00, cycle_count=0, load_err=0, word counter 0, loaded flag 0. Instruction memory contents are untouched.
- IDLE: cpu_nrst=0, cpu_nclear=0.
  - load_start with legal load_len -> LOAD; word counter=0, remaining=load_len.
  - Illegal load_len (0 or >2**ADDR_W): load_err pulses next cycle; state stays IDLE.
  - run_start is ignored (loaded flag is 0).
- LOAD: in_ready=1; cpu held in reset.
  - ins_wr_en = in_valid & in_ready (combinational); ins_wr_addr = word counter; ins_data = in_data. The memory writes on the same clk edge.
  - Each handshake increments the counter and decrements remaining.
  - Acceptance of the last word -> ARMED next cycle and loaded flag set. in_ready is low from ARMED onward.
  - No wrap: the counter never exceeds load_len-1.
  - load_start, run_start and abort are ignored while in LOAD.
- ARMED: run_start -> CLR; load_start -> LOAD (reload); if both are asserted, load_start wins.
- CLR: exactly one cycle; cpu_nclear=0, cpu_nrst=0; cycle_count cleared; halt_reason=00 -> RUN.
  - Latency: run_start at cycle n, CLR at n+1, first RUN cycle at n+2 with PC=0.
- RUN: cpu_nrst=1, cpu_nclear=1, wr_inhibit=0; cycle_count increments every RUN cycle, including the terminating one.
  - Exit priority in one cycle: abort (11) > instr==HALT_WORD (01) > cycle_count==2**CNT_W-2, i.e. the last allowed cycle (10). Any exit -> DONE next cycle.
  - wr_inhibit goes high the cycle after the exit condition. The halting instruction is a syscall and performs no writes.
- DONE: done=1, cpu_nrst=0, cpu_nclear=1 (registers retained for inspection), wr_inhibit=1; cycle_count and halt_reason hold.
  - load_start -> LOAD; run_start -> CLR (re-run); load_start wins if simultaneous.
  - Leaving DONE clears done; halt_reason clears in CLR.
- load_start asserted in RUN or CLR: ignored.
- clr asserted mid-operation: immediate IDLE with all reset values; any partial load is discarded (loaded flag 0); a run is killed with no further writes.

Decomposition:
- Shared package ctrl_pkg: state encoding constants, halt_reason codes (HR_NONE, HR_HALT, HR_TIMEOUT, HR_ABORT), default HALT_WORD.
- One sub-module, run_counter: a CNT_W counter with clear, enable and a terminal-count flag, used for cycle_count. The word counter stays inline.

Test Plan:
- Load 4 words (0x20010005, 0x20020003, 0x00221820, 0x0000000C) with in_valid continuous -> ins_wr_en high 4 cycles at addrs 0..3, ARMED after the 4th; run_start -> cpu_nrst rises 2 cycles later; halt_reason=01, cycle_count=4, done=1, $3=8.
- Load with in_valid toggling every other cycle, load_len=3 -> exactly 3 writes, addrs 0,1,2, no write while in_valid=0.
- load_len=0 and load_len=33 -> load_err single pulse; state stays IDLE; run_start ignored.
- CNT_W=4, program `beq $0,$0,-1` loop -> DONE with halt_reason=10, cycle_count=15, wr_inhibit high the next cycle.
- abort in the 3rd RUN cycle -> halt_reason=11, cycle_count=3; re-run from DONE -> CLR pulses cpu_nclear low one cycle, then identical results.
- clr asserted after 2 of 4 load words -> IDLE immediately, in_ready=0; a subsequent run_start is ignored until a full reload completes.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the program-run controller: FSM state encoding,
// halt-reason codes and the default halt instruction (syscall).
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ARMED = 3'd2,
    ST_CLR   = 3'd3,
    ST_RUN   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    HR_NONE    = 2'b00,
    HR_HALT    = 2'b01,
    HR_TIMEOUT = 2'b10,
    HR_ABORT   = 2'b11
  } halt_reason_t;

  localparam logic [31:0] DEFAULT_HALT_WORD = 32'h0000_000C;

endpackage

// File: rtl/prog_run_ctrl_run_counter.sv
// Run-cycle counter with synchronous clear, count enable and a flag that
// marks the last allowed run cycle (count == 2**CNT_W-2).
module run_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc
);

  localparam logic [CNT_W-1:0] LAST_CYCLE = {{(CNT_W-1){1'b1}}, 1'b0};

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == LAST_CYCLE);

endmodule

// File: rtl/prog_run_ctrl.sv
// Sequencing controller for the single-cycle MIPS datapath: loads a program
// into instruction memory, clears the register file, then runs to halt/limit/abort.
module prog_run_ctrl
  import ctrl_pkg::*;
#(
  parameter int               ADDR_W    = 5,
  parameter int               DATA_W    = 32,
  parameter logic [DATA_W-1:0] HALT_WORD = DEFAULT_HALT_WORD,
  parameter int               CNT_W     = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              run_start,
  input  logic              abort,
  input  logic [DATA_W-1:0] instr,
  output logic              ins_wr_en,
  output logic [ADDR_W-1:0] ins_wr_addr,
  output logic [DATA_W-1:0] ins_data,
  output logic              cpu_nrst,
  output logic              cpu_nclear,
  output logic              wr_inhibit,
  output logic              busy,
  output logic              done,
  output logic [1:0]        halt_reason,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              load_err,
  output state_t            dbg_state
);

  // Load handshake: a word transfers on every rising clk where
  // in_valid && in_ready; in_ready is high only in LOAD and the memory
  // write happens on that same edge.

  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ADDR_W-1:0] r_wcnt;
  logic [ADDR_W:0]   r_remain;
  logic              r_loaded;
  logic              r_load_err;
  halt_reason_t      r_halt_reason;
  halt_reason_t      w_halt_nxt;
  logic              w_load_err_nxt;
  logic              w_start_load;
  logic              w_len_ok;
  logic              w_accept;
  logic              w_last;
  logic              w_cnt_tc;
  logic [CNT_W-1:0]  w_count;

  assign w_len_ok = (load_len != '0) && (load_len <= LEN_MAX);
  assign w_accept = in_valid && (r_state == ST_LOAD);
  assign w_last   = w_accept && (r_remain == {{ADDR_W{1'b0}}, 1'b1});

  always_comb begin
    w_state_nxt    = r_state;
    w_halt_nxt     = r_halt_reason;
    w_load_err_nxt = 1'b0;
    w_start_load   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (load_start) begin
          if (w_len_ok) w_start_load = 1'b1;
          else          w_load_err_nxt = 1'b1;
        end else if (run_start && r_loaded) begin
          w_state_nxt = ST_CLR;
        end
      end
      ST_LOAD: begin
        if (w_last) w_state_nxt = ST_ARMED;
      end
      ST_ARMED, ST_DONE: begin
        // load_start takes precedence over run_start in the same cycle
        if (load_start) begin
          if (w_len_ok) w_start_load = 1'b1;
          else          w_load_err_nxt = 1'b1;
        end else if (run_start) begin
          w_state_nxt = ST_CLR;
        end
      end
      ST_CLR: begin
        w_halt_nxt  = HR_NONE;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (abort) begin
          w_halt_nxt  = HR_ABORT;
          w_state_nxt = ST_DONE;
        end else if (instr == HALT_WORD) begin
          w_halt_nxt  = HR_HALT;
          w_state_nxt = ST_DONE;
        end else if (w_cnt_tc) begin
          w_halt_nxt  = HR_TIMEOUT;
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_start_load) w_state_nxt = ST_LOAD;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state       <= ST_IDLE;
      r_wcnt        <= '0;
      r_remain      <= '0;
      r_loaded      <= 1'b0;
      r_load_err    <= 1'b0;
      r_halt_reason <= HR_NONE;
    end else begin
      r_state       <= w_state_nxt;
      r_load_err    <= w_load_err_nxt;
      r_halt_reason <= w_halt_nxt;
      if (w_start_load) begin
        r_wcnt   <= '0;
        r_remain <= load_len;
        r_loaded <= 1'b0;
      end else if (w_accept) begin
        r_remain <= r_remain - 1'b1;
        // hold on the final word so the address never passes load_len-1
        if (w_last) r_loaded <= 1'b1;
        else        r_wcnt   <= r_wcnt + 1'b1;
      end
    end
  end

  run_counter #(
    .CNT_W(CNT_W)
  ) u_run_counter (
    .i_clk  (clk),
    .i_rst  (clr),
    .i_clear(r_state == ST_CLR),
    .i_en   (r_state == ST_RUN),
    .o_count(w_count),
    .o_tc   (w_cnt_tc)
  );

  assign in_ready    = (r_state == ST_LOAD);
  assign ins_wr_en   = in_valid && in_ready;
  assign ins_wr_addr = r_wcnt;
  assign ins_data    = in_data;

  assign cpu_nrst    = (r_state == ST_RUN);
  assign cpu_nclear  = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign wr_inhibit  = (r_state != ST_RUN);
  assign busy        = (r_state == ST_LOAD) || (r_state == ST_CLR) || (r_state == ST_RUN);
  assign done        = (r_state == ST_DONE);
  assign halt_reason = r_halt_reason;
  assign cycle_count = w_count;
  assign load_err    = r_load_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Directed bench for prog_run_ctrl with a small behavioural MIPS model
// (instruction memory, PC, addi/add register file) driven by the controller.
module tb_prog_run_ctrl;
  import ctrl_pkg::*;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam logic [31:0] BEQ_SELF = 32'h1000_FFFF;

  logic              clk = 1'b0;
  logic              clr;
  logic              load_start;
  logic [ADDR_W:0]   load_len;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              run_start;
  logic              abort;
  logic [DATA_W-1:0] instr;
  logic              ins_wr_en;
  logic [ADDR_W-1:0] ins_wr_addr;
  logic [DATA_W-1:0] ins_data;
  logic              cpu_nrst;
  logic              cpu_nclear;
  logic              wr_inhibit;
  logic              busy;
  logic              done;
  logic [1:0]        halt_reason;
  logic [CNT_W-1:0]  cycle_count;
  logic              load_err;
  state_t            dbg_state;

  always #5 clk = ~clk;

  prog_run_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .clr(clr), .load_start(load_start), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .run_start(run_start), .abort(abort), .instr(instr),
    .ins_wr_en(ins_wr_en), .ins_wr_addr(ins_wr_addr), .ins_data(ins_data),
    .cpu_nrst(cpu_nrst), .cpu_nclear(cpu_nclear), .wr_inhibit(wr_inhibit),
    .busy(busy), .done(done), .halt_reason(halt_reason),
    .cycle_count(cycle_count), .load_err(load_err), .dbg_state(dbg_state)
  );

  // Datapath model: memory written by the controller, PC held by cpu_nrst,
  // register file cleared by cpu_nclear and guarded by wr_inhibit.
  logic [31:0]       imem [32];
  logic [31:0]       regs [32];
  logic [ADDR_W-1:0] pc;

  assign instr = imem[pc];

  always @(posedge clk) begin
    if (ins_wr_en) imem[ins_wr_addr] <= ins_data;
    if (!cpu_nrst) pc <= '0;
    else if (instr != BEQ_SELF) pc <= pc + 1'b1;
    if (!cpu_nclear) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (!wr_inhibit) begin
      if (instr[31:26] == 6'h08 && instr[20:16] != 5'd0)
        regs[instr[20:16]] <= regs[instr[25:21]] + {{16{instr[15]}}, instr[15:0]};
      else if (instr[31:26] == 6'h00 && instr[5:0] == 6'h20 && instr[15:11] != 5'd0)
        regs[instr[15:11]] <= regs[instr[25:21]] + regs[instr[20:16]];
    end
  end

  // Scoreboard of expected instruction-memory writes {addr, data}
  logic [ADDR_W+DATA_W-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  int wr_idx   = 0;
  logic [31:0] prog [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ins_wr_en) begin
      logic [ADDR_W+DATA_W-1:0] e;
      n_writes++;
      if (exp_q.size() == 0) begin
        chk("write_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 32'(ins_wr_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
        chk("write_data", ins_data, e[DATA_W-1:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int len);
    load_start = 1'b1;
    load_len   = len[ADDR_W:0];
    tick();
    load_start = 1'b0;
    wr_idx     = 0;
  endtask

  task automatic send_word(input logic [31:0] d, input int gap);
    logic acc;
    logic [ADDR_W-1:0] a;
    a        = wr_idx[ADDR_W-1:0];
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back({a, d});
    wr_idx++;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    if (!acc) chk("load_accept_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic load_prog(input int len, input int gap);
    start_load(len);
    for (int i = 0; i < len; i++) send_word(prog[i], gap);
    @(negedge clk);
    chk("armed_state", 32'(dbg_state), 32'(ST_ARMED));
    chk("armed_in_ready", 32'(in_ready), 32'd0);
    chk("armed_busy", 32'(busy), 32'd0);
    tick();
  endtask

  task automatic run_prog(input int abort_at, output int rc);
    logic seen;
    logic last_inh;
    run_start = 1'b1;
    @(negedge clk);
    chk("pre_run_nrst", 32'(cpu_nrst), 32'd0);
    tick();
    run_start = 1'b0;
    @(negedge clk);
    chk("clr_state", 32'(dbg_state), 32'(ST_CLR));
    chk("clr_nclear", 32'(cpu_nclear), 32'd0);
    chk("clr_nrst", 32'(cpu_nrst), 32'd0);
    chk("clr_busy", 32'(busy), 32'd1);
    rc = 0;
    seen = 1'b0;
    last_inh = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dbg_state == ST_RUN) begin
        rc++;
        if (rc == 1) begin
          chk("run1_nrst", 32'(cpu_nrst), 32'd1);
          chk("run1_count", 32'(cycle_count), 32'd0);
          chk("run1_halt_reason", 32'(halt_reason), 32'd0);
        end
        last_inh = wr_inhibit;
        if (rc == abort_at) abort = 1'b1;
      end else if (done) begin
        seen = 1'b1;
        break;
      end
    end
    abort = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    chk("run_inhibit_low", 32'(last_inh), 32'd0);
    chk("done_inhibit", 32'(wr_inhibit), 32'd1);
    chk("done_nrst", 32'(cpu_nrst), 32'd0);
    chk("done_nclear", 32'(cpu_nclear), 32'd1);
    tick();
  endtask

  initial begin
    int rc;
    int w0;
    for (int i = 0; i < 32; i++) begin
      imem[i] = '0;
      regs[i] = '0;
      prog[i] = '0;
    end
    clr = 1'b1; load_start = 1'b0; load_len = '0; in_valid = 1'b0;
    in_data = '0; run_start = 1'b0; abort = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_nrst", 32'(cpu_nrst), 32'd0);
    chk("rst_nclear", 32'(cpu_nclear), 32'd0);
    chk("rst_inhibit", 32'(wr_inhibit), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_halt_reason", 32'(halt_reason), 32'd0);
    chk("rst_count", 32'(cycle_count), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    tick();

    // Illegal lengths: single load_err pulse, stay IDLE; run_start ignored
    start_load(0);
    @(negedge clk);
    chk("len0_err", 32'(load_err), 32'd1);
    chk("len0_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    @(negedge clk);
    chk("len0_err_pulse", 32'(load_err), 32'd0);
    tick();
    start_load(33);
    @(negedge clk);
    chk("len33_err", 32'(load_err), 32'd1);
    chk("len33_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    @(negedge clk);
    chk("len33_err_pulse", 32'(load_err), 32'd0);
    tick();
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    @(negedge clk);
    chk("idle_run_ignored", 32'(dbg_state), 32'(ST_IDLE));
    tick();

    // Continuous load of 4 words, run to halt word
    prog[0] = 32'h2001_0005; prog[1] = 32'h2002_0003;
    prog[2] = 32'h0022_1820; prog[3] = 32'h0000_000C;
    w0 = n_writes;
    load_prog(4, 0);
    chk("load4_writes", 32'(n_writes - w0), 32'd4);
    run_prog(0, rc);
    chk("halt_reason", 32'(halt_reason), 32'(HR_HALT));
    chk("halt_count", 32'(cycle_count), 32'd4);
    chk("halt_rc", 32'(rc), 32'd4);
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_reg3", regs[3], 32'd8);

    // Reload from DONE with gaps between words
    prog[0] = 32'h2003_0007; prog[1] = 32'h0000_0000; prog[2] = 32'h0000_000C;
    w0 = n_writes;
    start_load(3);
    @(negedge clk);
    chk("reload_done_clr", 32'(done), 32'd0);
    chk("reload_busy", 32'(busy), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) send_word(prog[i], 1);
    @(negedge clk);
    chk("gap_state", 32'(dbg_state), 32'(ST_ARMED));
    chk("gap_writes", 32'(n_writes - w0), 32'd3);
    tick();
    run_prog(0, rc);
    chk("gap_halt_reason", 32'(halt_reason), 32'(HR_HALT));
    chk("gap_count", 32'(cycle_count), 32'd3);
    chk("gap_reg3", regs[3], 32'd7);

    // Self-loop runs into the cycle limit
    prog[0] = BEQ_SELF;
    load_prog(1, 0);
    run_prog(0, rc);
    chk("tmo_halt_reason", 32'(halt_reason), 32'(HR_TIMEOUT));
    chk("tmo_count", 32'(cycle_count), 32'd15);
    chk("tmo_rc", 32'(rc), 32'd15);

    // Abort in the third run cycle, then re-run from DONE
    prog[0] = 32'h2001_0005; prog[1] = 32'h2002_0003;
    prog[2] = 32'h0022_1820; prog[3] = 32'h0000_000C;
    load_prog(4, 0);
    run_prog(3, rc);
    chk("abort_halt_reason", 32'(halt_reason), 32'(HR_ABORT));
    chk("abort_count", 32'(cycle_count), 32'd3);
    run_prog(3, rc);
    chk("rerun_halt_reason", 32'(halt_reason), 32'(HR_ABORT));
    chk("rerun_count", 32'(cycle_count), 32'd3);
    chk("rerun_rc", 32'(rc), 32'd3);

    // Reset in the middle of a load
    start_load(4);
    send_word(prog[0], 0);
    send_word(prog[1], 0);
    clr = 1'b1;
    #1;
    chk("midclr_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("midclr_in_ready", 32'(in_ready), 32'd0);
    chk("midclr_inhibit", 32'(wr_inhibit), 32'd1);
    tick();
    clr = 1'b0;
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    @(negedge clk);
    chk("midclr_run_ignored", 32'(dbg_state), 32'(ST_IDLE));
    chk("midclr_nrst", 32'(cpu_nrst), 32'd0);
    tick();
    load_prog(4, 0);
    run_prog(0, rc);
    chk("final_halt_reason", 32'(halt_reason), 32'(HR_HALT));
    chk("final_count", 32'(cycle_count), 32'd4);
    chk("final_reg3", regs[3], 32'd8);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
